// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one single-precision FP multiplier among NUM_REQ requesters.
// Define FP_MUL_EXC_CNT_EN to add saturating overflow/underflow event counters (cnt_clr, ovrf_cnt, udrf_cnt).
module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*32-1:0]        req_x,
  input  logic [NUM_REQ*32-1:0]        req_y,
  input  logic [NUM_REQ*3-1:0]         req_mode,
  output logic [31:0]                  mul_x,
  output logic [31:0]                  mul_y,
  output logic [2:0]                   mul_mode,
  input  logic [31:0]                  mul_z,
  input  logic                         mul_ovrf,
  input  logic                         mul_udrf,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [31:0]                  rsp_z,
  output logic                         rsp_ovrf,
  output logic                         rsp_udrf,
  output logic                         busy
`ifdef FP_MUL_EXC_CNT_EN
  ,
  input  logic                         cnt_clr,
  output logic [CNT_W-1:0]             ovrf_cnt,
  output logic [CNT_W-1:0]             udrf_cnt
`endif
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int LAT_W = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cur_id;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  idx;
  logic [LAT_W-1:0] wait_cnt;
  logic             found;

  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] w);
    return (w == ID_W'(NUM_REQ - 1)) ? '0 : w + ID_W'(1);
  endfunction

  // Scan from the round-robin pointer, wrapping, for the first pending request.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    req_ready = '0;
    if (state == IDLE && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      wait_cnt  <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
      mul_mode  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_z     <= '0;
      rsp_ovrf  <= 1'b0;
      rsp_udrf  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            mul_x    <= req_x[int'(winner)*32 +: 32];
            mul_y    <= req_y[int'(winner)*32 +: 32];
            mul_mode <= req_mode[int'(winner)*3 +: 3];
            cur_id   <= winner;
            rr_ptr   <= ptr_after(winner);
            wait_cnt <= LAT_W'(MUL_LAT);
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - LAT_W'(1);
          // Only the last cycle of the latency window carries a settled product.
          if (wait_cnt == LAT_W'(1)) begin
            rsp_z     <= mul_z;
            rsp_ovrf  <= mul_ovrf;
            rsp_udrf  <= mul_udrf;
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FP_MUL_EXC_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Counters sample the strobed flags; a clear in the same cycle takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovrf_cnt <= '0;
      udrf_cnt <= '0;
    end else if (cnt_clr) begin
      ovrf_cnt <= '0;
      udrf_cnt <= '0;
    end else if (state == RESP) begin
      if (rsp_ovrf) ovrf_cnt <= sat_inc(ovrf_cnt);
      if (rsp_udrf) udrf_cnt <= sat_inc(udrf_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: acts as a 3-cycle FP multiplier and checks against a transaction-level model.
`timescale 1ns/1ps
module tb_fp_mul_arbiter;
  localparam int N   = 4;
  localparam int LAT = 3;
`ifdef FP_MUL_EXC_CNT_EN
  localparam int CW  = 4;
`else
  localparam int CW  = 16;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  logic [N*32-1:0]      req_x = '0;
  logic [N*32-1:0]      req_y = '0;
  logic [N*3-1:0]       req_mode = '0;
  logic [31:0]          mul_x, mul_y;
  logic [2:0]           mul_mode;
  logic [31:0]          mul_z = '0;
  logic                 mul_ovrf = 1'b0, mul_udrf = 1'b0;
  logic                 rsp_valid;
  logic [$clog2(N)-1:0] rsp_id;
  logic [31:0]          rsp_z;
  logic                 rsp_ovrf, rsp_udrf, busy;
`ifdef FP_MUL_EXC_CNT_EN
  logic                 cnt_clr = 1'b0;
  logic [CW-1:0]        ovrf_cnt, udrf_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.NUM_REQ(N), .MUL_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_mode(req_mode),
    .mul_x(mul_x), .mul_y(mul_y), .mul_mode(mul_mode),
    .mul_z(mul_z), .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_ovrf(rsp_ovrf), .rsp_udrf(rsp_udrf), .busy(busy)
`ifdef FP_MUL_EXC_CNT_EN
    , .cnt_clr(cnt_clr), .ovrf_cnt(ovrf_cnt), .udrf_cnt(udrf_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Normal-operand single-precision product with truncation: {ovrf, udrf, z}.
  function automatic logic [33:0] fpmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    logic        s;
    s = a[31] ^ b[31];
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b01, s, 31'd0};
    return {2'b00, s, e[7:0], m};
  endfunction

  // Multiplier stand-in: product is presented only once operands have been stable LAT cycles.
  logic [66:0] last_ops = '0;
  int          scnt = 0;
  always @(posedge clk) begin
    logic [33:0] r;
    #1;
    if ({mul_x, mul_y, mul_mode} == last_ops) scnt = scnt + 1;
    else begin
      scnt = 1;
      last_ops = {mul_x, mul_y, mul_mode};
    end
    if (scnt >= LAT) r = fpmul(mul_x, mul_y);
    else r = {2'b11, 32'hDEAD0000 | 32'(scnt)};
    {mul_ovrf, mul_udrf, mul_z} = r;
  end

  // Transaction model: round-robin pointer, busy window and due cycle of the one op in flight.
  int          cyc = 0, m_ptr = 0, m_free = 0, m_due = -1, m_id = 0;
  logic [31:0] m_x = '0, m_y = '0;
  logic [2:0]  m_mode = '0;
  logic        m_pend = 1'b0;
  logic [31:0] e_mx = '0, e_my = '0, e_rz = '0;
  logic [2:0]  e_mm = '0;
  int          e_rid = 0;
  logic        e_ro = 1'b0, e_ru = 1'b0;
  int          rsp_log[$];

  always @(negedge clk) begin
    logic [N-1:0] e_ready;
    logic         e_busy, e_rv, fnd;
    logic [33:0]  r;
    cyc++;
    if (!rst_n) begin
      m_ptr = 0; m_free = 0; m_due = -1; m_pend = 1'b0;
      e_mx = '0; e_my = '0; e_mm = '0; e_rid = 0; e_rz = '0; e_ro = 1'b0; e_ru = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_z", 64'(rsp_z), 64'd0);
      chk("rst_mul_x", 64'(mul_x), 64'd0);
    end else begin
      e_busy  = (cyc < m_free);
      e_rv    = (cyc == m_due);
      e_ready = '0;
      if (m_pend) begin
        e_mx = m_x; e_my = m_y; e_mm = m_mode; m_pend = 1'b0;
      end
      if (e_rv) begin
        r = fpmul(m_x, m_y);
        e_rid = m_id; e_rz = r[31:0]; e_ro = r[33]; e_ru = r[32];
      end
      if (!e_busy) begin
        fnd = 1'b0;
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (!fnd && req_valid[i]) begin
            fnd = 1'b1;
            e_ready[i] = 1'b1;
            m_id = i; m_x = req_x[32*i +: 32]; m_y = req_y[32*i +: 32]; m_mode = req_mode[3*i +: 3];
            m_due = cyc + LAT + 1; m_free = cyc + LAT + 2; m_ptr = (i + 1) % N; m_pend = 1'b1;
          end
        end
      end
      if (rsp_valid) rsp_log.push_back(int'(rsp_id));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("rsp_id", 64'(rsp_id), 64'(e_rid));
      chk("rsp_z", 64'(rsp_z), 64'(e_rz));
      chk("rsp_flags", 64'({rsp_ovrf, rsp_udrf}), 64'({e_ro, e_ru}));
      chk("mul_ops", 64'({mul_x, mul_y}), {e_mx, e_my});
      chk("mul_mode", 64'(mul_mode), 64'(e_mm));
    end
  end

  task automatic do_op(input int id, input logic [31:0] x, input logic [31:0] y,
                       input logic [2:0] md, output int lat);
    logic granted;
    @(posedge clk); #1;
    req_x[32*id +: 32] = x; req_y[32*id +: 32] = y; req_mode[3*id +: 3] = md;
    req_valid[id] = 1'b1;
    granted = 1'b0;
    lat = -1;
    for (int n = 0; n < 40 && !granted; n++) begin
      @(negedge clk);
      if (req_ready[id]) granted = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!granted) chk("grant_timeout", 64'd0, 64'd1);
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      @(negedge clk);
      if (rsp_valid) lat = n;
    end
    if (lat < 0) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int lat, pulses;
    logic got;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_ready", 64'(req_ready), 64'd0);

    // 1.0 * 2.0 from requester 0
    do_op(0, 32'h3F800000, 32'h40000000, 3'd0, lat);
    chk("t1_latency", 64'(lat), 64'(LAT + 1));
    chk("t1_id", 64'(rsp_id), 64'd0);
    chk("t1_z", 64'(rsp_z), 64'h40000000);
    chk("t1_flags", 64'({rsp_ovrf, rsp_udrf}), 64'd0);

    // Overflow, underflow and an exact normal product
    do_op(1, 32'h7F000000, 32'h7F000000, 3'd0, lat);
    chk("t3_ovf_z", 64'(rsp_z), 64'h7F800000);
    chk("t3_ovf_flag", 64'(rsp_ovrf), 64'd1);
    do_op(2, 32'h00800000, 32'h00800000, 3'd0, lat);
    chk("t3_udf_flag", 64'(rsp_udrf), 64'd1);
    chk("t3_udf_id", 64'(rsp_id), 64'd2);
    do_op(3, 32'h3FC00000, 32'h3FC00000, 3'd5, lat);
    chk("t3_mul_z", 64'(rsp_z), 64'h40100000);
    chk("t3_mul_mode", 64'(mul_mode), 64'd5);

    // Reset while an operation is waiting on the multiplier
    @(posedge clk); #1;
    req_x[63:32] = 32'h40400000; req_y[63:32] = 32'h40400000; req_valid[1] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ready[1]) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("t5_grant", 64'(got), 64'd1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t5_busy_wait", 64'(busy), 64'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t5_busy_rst", 64'(busy), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    pulses = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("t5_no_rsp", 64'(pulses), 64'd0);

    // All requesters held valid: round robin from requester 0
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      req_x[32*i +: 32] = 32'h3F800000;
      req_y[32*i +: 32] = 32'h40000000 + (32'(i) << 22);
      req_mode[3*i +: 3] = 3'(i);
    end
    rsp_log.delete();
    req_valid = '1;
    for (int n = 0; n < 80 && rsp_log.size() < 5; n++) @(negedge clk);
    @(posedge clk); #1 req_valid = '0;
    repeat (2 * (LAT + 2)) @(negedge clk);
    chk("t2_count", 64'(rsp_log.size() >= 5), 64'd1);
    if (rsp_log.size() >= 5) begin
      chk("t2_order0", 64'(rsp_log[0]), 64'd0);
      chk("t2_order1", 64'(rsp_log[1]), 64'd1);
      chk("t2_order2", 64'(rsp_log[2]), 64'd2);
      chk("t2_order3", 64'(rsp_log[3]), 64'd3);
      chk("t2_order4", 64'(rsp_log[4]), 64'd0);
    end

`ifdef FP_MUL_EXC_CNT_EN
    @(posedge clk); #1 cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    chk("cnt_cleared", 64'({ovrf_cnt, udrf_cnt}), 64'd0);
    repeat (3) do_op(1, 32'h7F000000, 32'h7F000000, 3'd0, lat);
    @(posedge clk); #1;
    chk("cnt_ovrf3", 64'(ovrf_cnt), 64'd3);
    chk("cnt_udrf0", 64'(udrf_cnt), 64'd0);
    do_op(2, 32'h7F000000, 32'h7F000000, 3'd0, lat);
    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    chk("cnt_clr_wins", 64'(ovrf_cnt), 64'd0);
    do_op(0, 32'h00800000, 32'h00800000, 3'd0, lat);
    @(posedge clk); #1;
    chk("cnt_udrf1", 64'(udrf_cnt), 64'd1);
    repeat (16) do_op(3, 32'h7F000000, 32'h7F000000, 3'd0, lat);
    @(posedge clk); #1;
    chk("cnt_sat", 64'(ovrf_cnt), 64'(CW'('1)));
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
